// File: rtl/video_scan_gen.sv
// Raster scan generator: pixel-enable divider, h/v timing, text-cell counters and
// frame-synchronous colour registers. Define VIDEO_SCAN_LINE_IRQ_EN for the line-compare irq.
module video_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned CELL_W   = 8,
  parameter int unsigned CELL_H   = 8,
  parameter int unsigned HSZ      = 10,
  parameter int unsigned VSZ      = 10,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            clk_100mhz,
  input  logic            rstn_i,
  input  logic            i_we,
  input  logic [1:0]      i_addr,
  input  logic [11:0]     i_wdata,
  output logic            o_pix_ce,
  output logic [HSZ-1:0]  o_hcount,
  output logic [VSZ-1:0]  o_vcount,
  output logic            o_de,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_frame_start,
  output logic [3:0]      o_cell_col,
  output logic [3:0]      o_cell_row,
  output logic [7:0]      o_text_col,
  output logic [5:0]      o_text_row,
  output logic [11:0]     o_fg_color,
  output logic [11:0]     o_bg_color,
  output logic            o_irq
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]     DIV_LAST  = 4'(PIX_DIV - 1);
  localparam logic [HSZ-1:0] H_LAST    = HSZ'(H_TOTAL - 1);
  localparam logic [VSZ-1:0] V_LAST    = VSZ'(V_TOTAL - 1);
  localparam logic [HSZ-1:0] H_ACT     = HSZ'(H_ACTIVE);
  localparam logic [VSZ-1:0] V_ACT     = VSZ'(V_ACTIVE);
  localparam logic [HSZ-1:0] HS_FIRST  = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0] HS_LAST   = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VSZ-1:0] VS_FIRST  = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0] VS_LAST   = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0]     CW_LAST   = 4'(CELL_W - 1);
  localparam logic [3:0]     CH_LAST   = 4'(CELL_H - 1);

  logic [3:0]     r_div;
  logic [HSZ-1:0] r_hcount;
  logic [VSZ-1:0] r_vcount;
  logic [3:0]     r_cell_col;
  logic [3:0]     r_cell_row;
  logic [7:0]     r_text_col;
  logic [5:0]     r_text_row;
  logic [11:0]    r_fg_pend;
  logic [11:0]    r_bg_pend;
  logic [11:0]    r_fg;
  logic [11:0]    r_bg;

  logic w_pix_ce;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_hs_act;
  logic w_vs_act;

  assign w_pix_ce = (r_div == DIV_LAST);
  assign w_h_wrap = w_pix_ce & (r_hcount == H_LAST);
  assign w_v_wrap = w_h_wrap & (r_vcount == V_LAST);

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div <= '0;
    end else if (w_pix_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hcount   <= '0;
      r_cell_col <= '0;
      r_text_col <= '0;
    end else if (w_pix_ce) begin
      if (w_h_wrap) begin
        r_hcount   <= '0;
        r_cell_col <= '0;
        r_text_col <= '0;
      end else begin
        r_hcount <= r_hcount + 1'b1;
        if (r_cell_col == CW_LAST) begin
          r_cell_col <= '0;
          r_text_col <= r_text_col + 1'b1;
        end else begin
          r_cell_col <= r_cell_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vcount   <= '0;
      r_cell_row <= '0;
      r_text_row <= '0;
    end else if (w_h_wrap) begin
      if (w_v_wrap) begin
        r_vcount   <= '0;
        r_cell_row <= '0;
        r_text_row <= '0;
      end else begin
        r_vcount <= r_vcount + 1'b1;
        if (r_cell_row == CH_LAST) begin
          r_cell_row <= '0;
          r_text_row <= r_text_row + 1'b1;
        end else begin
          r_cell_row <= r_cell_row + 1'b1;
        end
      end
    end
  end

  // Pending colours take writes at any time; active colours only change at frame start,
  // using the value pending before any write in that same clk.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fg_pend <= 12'hFFF;
      r_bg_pend <= 12'h000;
    end else if (i_we) begin
      case (i_addr)
        2'd0:    r_fg_pend <= i_wdata;
        2'd1:    r_bg_pend <= i_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fg <= 12'hFFF;
      r_bg <= 12'h000;
    end else if (w_v_wrap) begin
      r_fg <= r_fg_pend;
      r_bg <= r_bg_pend;
    end
  end

`ifdef VIDEO_SCAN_LINE_IRQ_EN
  logic [VSZ-1:0] r_line_cmp;
  logic           r_irq;
  logic [VSZ-1:0] w_vcount_nxt;

  assign w_vcount_nxt = w_v_wrap ? '0 : r_vcount + 1'b1;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      r_line_cmp <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (i_we && (i_addr == 2'd2)) begin
        r_line_cmp <= i_wdata[VSZ-1:0];
      end
      if (w_h_wrap && (w_vcount_nxt == r_line_cmp)) begin
        r_irq <= 1'b1;
      end else if (i_we && (i_addr == 2'd3)) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

  assign w_hs_act = (r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST);
  assign w_vs_act = (r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST);

  assign o_pix_ce      = w_pix_ce;
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_de          = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign o_hsync       = w_hs_act ? SYNC_POL : ~SYNC_POL;
  assign o_vsync       = w_vs_act ? SYNC_POL : ~SYNC_POL;
  assign o_frame_start = w_v_wrap;
  assign o_cell_col    = r_cell_col;
  assign o_cell_row    = r_cell_row;
  assign o_text_col    = r_text_col;
  assign o_text_row    = r_text_row;
  assign o_fg_color    = r_fg;
  assign o_bg_color    = r_bg;

endmodule

// File: tb/tb_video_scan_gen.sv
// Randomised bench for video_scan_gen on a shrunk raster; expected outputs come from
// the elapsed clk count since reset release plus a register-level colour/irq model.
module tb_video_scan_gen;

  localparam int unsigned D   = 3;
  localparam int unsigned HA  = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA  = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned CW  = 4,  CH = 3;
  localparam int unsigned HT  = HA + HF + HS + HB;
  localparam int unsigned VT  = VA + VF + VS + VB;
  localparam int unsigned FRAME_CLKS = HT * VT * D;

  logic        clk_100mhz = 1'b0;
  logic        rstn_i     = 1'b0;
  logic        i_we       = 1'b0;
  logic [1:0]  i_addr     = '0;
  logic [11:0] i_wdata    = '0;
  logic        o_pix_ce, o_de, o_hsync, o_vsync, o_frame_start, o_irq;
  logic [9:0]  o_hcount, o_vcount;
  logic [3:0]  o_cell_col, o_cell_row;
  logic [7:0]  o_text_col;
  logic [5:0]  o_text_row;
  logic [11:0] o_fg_color, o_bg_color;

  video_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_DIV(D), .CELL_W(CW), .CELL_H(CH), .HSZ(10), .VSZ(10), .SYNC_POL(1'b0)
  ) u_dut (
    .clk_100mhz   (clk_100mhz),
    .rstn_i       (rstn_i),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_pix_ce     (o_pix_ce),
    .o_hcount     (o_hcount),
    .o_vcount     (o_vcount),
    .o_de         (o_de),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_frame_start(o_frame_start),
    .o_cell_col   (o_cell_col),
    .o_cell_row   (o_cell_row),
    .o_text_col   (o_text_col),
    .o_text_row   (o_text_row),
    .o_fg_color   (o_fg_color),
    .o_bg_color   (o_bg_color),
    .o_irq        (o_irq)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model state: clks elapsed since reset release, plus register contents.
  int unsigned t = 0;
  logic [11:0] m_fg_pend = 12'hFFF, m_bg_pend = 12'h000, m_fg = 12'hFFF, m_bg = 12'h000;
  logic [9:0]  m_lc = '0;
  logic        m_irq = 1'b0;
  logic [11:0] n_fg_pend, n_bg_pend, n_fg, n_bg;
  logic [9:0]  n_lc;
  logic        n_irq;
  int unsigned cyc = 0, last_fs = 0;
  bit          have_fs = 1'b0;

  function automatic bit m_ce(input int unsigned tt);
    return (tt % D) == D - 1;
  endfunction
  function automatic int unsigned m_h(input int unsigned tt);
    return (tt / D) % HT;
  endfunction
  function automatic int unsigned m_v(input int unsigned tt);
    return ((tt / D) / HT) % VT;
  endfunction
  function automatic bit m_fs(input int unsigned tt);
    return m_ce(tt) && m_h(tt) == HT - 1 && m_v(tt) == VT - 1;
  endfunction
  function automatic bit m_irq_set(input int unsigned tt, input logic [9:0] lc);
`ifdef VIDEO_SCAN_LINE_IRQ_EN
    return m_ce(tt) && m_h(tt) == HT - 1 && ((m_v(tt) + 1) % VT) == lc;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    t = 0; m_fg_pend = 12'hFFF; m_bg_pend = 12'h000; m_fg = 12'hFFF; m_bg = 12'h000;
    m_lc = '0; m_irq = 1'b0; have_fs = 1'b0;
  endtask

  task automatic check_all();
    int unsigned h, v;
    bit hs_in, vs_in;
    h = m_h(t);
    v = m_v(t);
    hs_in = (h >= HA + HF) && (h < HA + HF + HS);
    vs_in = (v >= VA + VF) && (v < VA + VF + VS);
    check_eq("pix_ce", o_pix_ce, m_ce(t));
    check_eq("hcount", o_hcount, h);
    check_eq("vcount", o_vcount, v);
    check_eq("de", o_de, (h < HA) && (v < VA));
    check_eq("hsync", o_hsync, !hs_in);
    check_eq("vsync", o_vsync, !vs_in);
    check_eq("frame_start", o_frame_start, m_fs(t));
    check_eq("cell_col", o_cell_col, h % CW);
    check_eq("text_col", o_text_col, (h / CW) % 256);
    check_eq("cell_row", o_cell_row, v % CH);
    check_eq("text_row", o_text_row, (v / CH) % 64);
    check_eq("fg_color", o_fg_color, m_fg);
    check_eq("bg_color", o_bg_color, m_bg);
    check_eq("irq", o_irq, m_irq);
  endtask

  task automatic drive();
    i_we = 1'b0;
    if (rstn_i) begin
      if (m_fs(t) && ($urandom % 2 == 0)) begin
        i_we = 1'b1; i_addr = 2'($urandom % 2); i_wdata = 12'($urandom);
      end else if (m_irq_set(t, m_lc) && ($urandom % 2 == 0)) begin
        i_we = 1'b1; i_addr = 2'd3; i_wdata = 12'($urandom);
      end else if ($urandom % 40 == 0) begin
        i_we = 1'b1; i_addr = 2'($urandom % 4);
        i_wdata = (i_addr == 2'd2) ? 12'($urandom_range(0, VT - 1)) : 12'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk_100mhz);
    cyc++;
    check_all();
    if (rstn_i && o_frame_start) begin
      if (have_fs) check_eq("fs_period", cyc - last_fs, FRAME_CLKS);
      have_fs = 1'b1;
      last_fs = cyc;
    end
    n_fg      = m_fs(t) ? m_fg_pend : m_fg;
    n_bg      = m_fs(t) ? m_bg_pend : m_bg;
    n_fg_pend = (i_we && i_addr == 2'd0) ? i_wdata : m_fg_pend;
    n_bg_pend = (i_we && i_addr == 2'd1) ? i_wdata : m_bg_pend;
    n_lc      = m_lc;
    n_irq     = m_irq;
`ifdef VIDEO_SCAN_LINE_IRQ_EN
    if (i_we && i_addr == 2'd2) n_lc = i_wdata[9:0];
    if (m_irq_set(t, m_lc)) n_irq = 1'b1;
    else if (i_we && i_addr == 2'd3) n_irq = 1'b0;
`endif
    @(posedge clk_100mhz);
    if (rstn_i) begin
      t++;
      m_fg = n_fg; m_bg = n_bg; m_fg_pend = n_fg_pend; m_bg_pend = n_bg_pend;
      m_lc = n_lc; m_irq = n_irq;
    end
    #1;
    drive();
  endtask

  initial begin
    repeat (4) step();
    rstn_i = 1'b1;
    for (int i = 0; i < 5 * FRAME_CLKS + 50; i++) step();
    // Mid-frame reset: outputs must drop to reset values without waiting for a clock.
    while (m_v(t) != 10) step();
    rstn_i = 1'b0;
    i_we   = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (5) step();
    rstn_i = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLKS + 20; i++) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_scan_gen.md
VIDEO_SCAN_GEN -- requirements
Module: video_scan_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE 640: visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48: horizontal porch/sync widths in pixels
- V_ACTIVE 480: visible lines
- V_FP 10, V_SYNC 2, V_BP 33: vertical porch/sync widths in lines
- PIX_DIV 4: clk_100mhz cycles per pixel (2..16)
- CELL_W 8, CELL_H 8: glyph cell size in pixels/lines (1..16)
- HSZ 10, VSZ 10: counter widths
- SYNC_POL 0: 0 = active-low sync, 1 = active-high sync
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_100mhz  in  1  system clock
- rstn_i  in  1  reset
- i_we  in  1  register write strobe, one clk per write
- i_addr  in  2  register select: 0 = fg, 1 = bg, 2 = line compare, 3 = irq ack
- i_wdata  in  12  write data; color RGB444; line compare uses [VSZ-1:0]
- o_pix_ce  out  1  pixel clock enable
- o_hcount  out  HSZ  pixel counter
- o_vcount  out  VSZ  line counter
- o_de  out  1  active video
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_frame_start  out  1  frame start pulse
- o_cell_col  out  4  pixel within cell
- o_cell_row  out  4  line within cell
- o_text_col  out  8  cell column index
- o_text_row  out  6  cell row index
- o_fg_color  out  12  active foreground color
- o_bg_color  out  12  active background color
- o_irq  out  1  line-compare interrupt
REQ-003 Reset is rstn_i, asynchronous, active-low; the clock is clk_100mhz.

Function
REQ-004 A divider counter SHALL count 0..PIX_DIV-1 and wrap; o_pix_ce SHALL be 1 for exactly the one clk per wrap in which the divider equals PIX_DIV-1.
REQ-005 All counters SHALL advance only on clks with o_pix_ce=1.
- o_hcount SHALL wrap from H_TOTAL-1 (H_TOTAL = sum of horizontal parameters) to 0.
- o_vcount SHALL increment on each hcount wrap and wrap from V_TOTAL-1 to 0.
REQ-006 o_de SHALL equal (hcount < H_ACTIVE) and (vcount < V_ACTIVE) from the current registered counter values, with zero extra latency.
REQ-007 Horizontal sync SHALL be asserted (at SYNC_POL) for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical sync SHALL follow the same rule on vcount.
REQ-008 o_cell_col SHALL count 0..CELL_W-1 and wrap, incrementing o_text_col on each wrap; both SHALL clear on an hcount wrap.
- o_cell_row/o_text_row SHALL behave the same way on hcount wraps, clearing on a vcount wrap.
- o_text_col and o_text_row SHALL wrap modulo their width.
REQ-009 o_frame_start SHALL pulse for one clk on the pix_ce clk in which the counters transition to (0,0).
REQ-010 Color writes SHALL go to pending registers.
- The pending values SHALL be copied to o_fg_color/o_bg_color on the o_frame_start clk.
- A write in that same clk SHALL update pending only; the copy uses the pre-write value, and the new value is applied at the next frame.
REQ-011 Writes to an address while i_we=0 SHALL have no effect.

Reset
REQ-012 While rstn_i=0 all counters SHALL be 0.
- o_pix_ce, o_frame_start and o_irq SHALL be 0.
- Syncs SHALL be inactive.
- fg (active and pending) SHALL be 12'hFFF; bg SHALL be 12'h000; line compare SHALL be 0.
REQ-013 Reset asserted mid-frame SHALL take effect immediately. After release, the first o_pix_ce SHALL occur PIX_DIV clks later, and hcount reaches 1 on that clk.

Configuration
REQ-014 With macro VIDEO_SCAN_LINE_IRQ_EN defined:
- o_irq SHALL set on the pix_ce clk where hcount wraps and the new vcount equals the line compare register.
- o_irq SHALL clear on a write to address 3.
- If set and ack occur in the same clk, set wins.
REQ-015 Without VIDEO_SCAN_LINE_IRQ_EN:
- o_irq SHALL be constant 0.
- Writes to addresses 2 and 3 SHALL be ignored.
- No line compare register SHALL be synthesised.

Verification
REQ-016 Release reset, count clks -> o_pix_ce period 4 clks; H_TOTAL=800 pixels per line, V_TOTAL=525 lines per frame, o_frame_start every 1,680,000 clks.
REQ-017 Check hcount 655/656/751/752 -> o_hsync 1/0/0/1 with SYNC_POL=0; o_de=0 at hcount 640 and at vcount 480.
REQ-018 Write fg=12'h0F0 at vcount 100 -> o_fg_color stays 12'hFFF until the next o_frame_start, then 12'h0F0; a write coincident with o_frame_start appears one frame later.
REQ-019 hcount 0..15 on line 9 -> o_cell_col 0..7,0..7; o_text_col 0,1; o_cell_row 1; o_text_row 1.
REQ-020 Macro on, line compare=200 -> o_irq rises as vcount becomes 200; an ack write clears it; an ack on the set clk leaves it 1. Macro off -> o_irq stays 0.
REQ-021 Assert rstn_i=0 at vcount 300 -> all outputs at reset values within the same clk; after release, first o_frame_start after one full frame.
